// File: rtl/uart_msg_assembler_if.sv
// Stream interface of the UART message assembler.
// The receiver-side byte strobe and the downstream valid/ready payload
// stream, plus the per-message status pulses.
// The slave modport is the assembler. The master modport is the
// byte source and payload sink around it.
interface uart_msg_assembler_if #(
  parameter int BYTE_SIZE = 8
);
  logic                 in_valid;
  logic [BYTE_SIZE-1:0] in_data;
  logic                 in_err;
  logic                 out_ready;
  logic                 out_valid;
  logic [BYTE_SIZE-1:0] out_data;
  logic                 out_last;
  logic                 msg_done;
  logic                 msg_bad;
  logic                 overrun;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_err, out_ready,
    input  out_valid, out_data, out_last, msg_done, msg_bad, overrun, busy
  );

  modport slave (
    input  in_valid, in_data, in_err, out_ready,
    output out_valid, out_data, out_last, msg_done, msg_bad, overrun, busy
  );
endinterface

// File: rtl/uart_msg_assembler.sv
// Message assembler that sits behind the UART byte receiver.
// It parses length-prefixed messages into a local buffer. A message is
// streamed out (store-and-forward) only after it has been fully accepted.
// Malformed messages are dropped and reported with a msg_bad pulse.
// Optional feature macro: UART_MSG_CSUM_EN. When it is defined, each message
// carries a trailing additive checksum byte, which is checked before the
// message is released.
module uart_msg_assembler #(
  parameter int BYTE_SIZE = 8,
  parameter int MAX_LEN   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_msg_assembler_if.slave  msg_if
);
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [BYTE_SIZE-1:0] MAX_LEN_B = BYTE_SIZE'(MAX_LEN);

  localparam logic [1:0] ST_LEN     = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
`ifdef UART_MSG_CSUM_EN
  localparam logic [1:0] ST_CSUM    = 2'd2;
`endif
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]           state_q,    state_d;
  logic [IDX_W-1:0]     len_q,      len_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [IDX_W-1:0]     rd_idx_q,   rd_idx_d;
`ifdef UART_MSG_CSUM_EN
  logic [BYTE_SIZE-1:0] sum_q,      sum_d;
`endif
  logic                 out_valid_q, out_valid_d;
  logic [BYTE_SIZE-1:0] out_data_q,  out_data_d;
  logic                 out_last_q,  out_last_d;
  logic                 msg_done_q,  msg_done_d;
  logic                 msg_bad_q,   msg_bad_d;
  logic                 overrun_q,   overrun_d;
  logic                 busy_q,      busy_d;
  logic                 buf_we;
  logic [BYTE_SIZE-1:0] buf_q [MAX_LEN];
  logic [IDX_W-1:0]     rd_nxt;

  assign rd_nxt = rd_idx_q + IDX_W'(1);

  // Next-state logic for the parser FSM, the drain pointer and the registered outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
`ifdef UART_MSG_CSUM_EN
    sum_d       = sum_q;
`endif
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    msg_done_d  = 1'b0;
    msg_bad_d   = 1'b0;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;
    case (state_q)
      ST_LEN: begin
        if (msg_if.in_valid) begin
          if (msg_if.in_data == '0 || msg_if.in_data > MAX_LEN_B) begin
            msg_bad_d = 1'b1;
          end else begin
            len_d   = msg_if.in_data[IDX_W-1:0];
`ifdef UART_MSG_CSUM_EN
            sum_d   = msg_if.in_data;
`endif
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (msg_if.in_err) begin
          msg_bad_d = 1'b1;
          state_d   = ST_LEN;
        end else if (msg_if.in_valid) begin
          buf_we = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
`ifdef UART_MSG_CSUM_EN
          sum_d  = sum_q + msg_if.in_data;
`endif
          if (idx_q == len_q - IDX_W'(1)) begin
`ifdef UART_MSG_CSUM_EN
            state_d = ST_CSUM;
`else
            // A one-byte message has not reached the buffer yet, so forward it directly.
            state_d     = ST_DRAIN;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = (idx_q == '0) ? msg_if.in_data : buf_q[0];
            out_last_d  = (len_q == IDX_W'(1));
`endif
          end
        end
      end
`ifdef UART_MSG_CSUM_EN
      ST_CSUM: begin
        if (msg_if.in_err) begin
          msg_bad_d = 1'b1;
          state_d   = ST_LEN;
        end else if (msg_if.in_valid) begin
          if (msg_if.in_data == sum_q) begin
            state_d     = ST_DRAIN;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = buf_q[0];
            out_last_d  = (len_q == IDX_W'(1));
          end else begin
            msg_bad_d = 1'b1;
            state_d   = ST_LEN;
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (msg_if.in_valid) begin
          overrun_d = 1'b1;
        end
        if (out_valid_q && msg_if.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            msg_done_d  = 1'b1;
            state_d     = ST_LEN;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = buf_q[rd_nxt[AW-1:0]];
            out_last_d = (rd_nxt == len_q - IDX_W'(1));
          end
        end
      end
      default: begin
        state_d = ST_LEN;
      end
    endcase
    busy_d = (state_d != ST_LEN);
  end

  // Control and output registers, synchronously cleared by RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_LEN;
      len_q       <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
`ifdef UART_MSG_CSUM_EN
      sum_q       <= '0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      msg_done_q  <= 1'b0;
      msg_bad_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
`ifdef UART_MSG_CSUM_EN
      sum_q       <= sum_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      msg_done_q  <= msg_done_d;
      msg_bad_q   <= msg_bad_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Payload buffer. It is not reset, because a stale message is never read back after RST.
  always_ff @(posedge CLK) begin
    if (buf_we) begin
      buf_q[idx_q[AW-1:0]] <= msg_if.in_data;
    end
  end

  assign msg_if.out_valid = out_valid_q;
  assign msg_if.out_data  = out_data_q;
  assign msg_if.out_last  = out_last_q;
  assign msg_if.msg_done  = msg_done_q;
  assign msg_if.msg_bad   = msg_bad_q;
  assign msg_if.overrun   = overrun_q;
  assign msg_if.busy      = busy_q;
endmodule

// File: doc/uart_msg_assembler.md
# uart_msg_assembler

Message-level stage directly downstream of the UART byte receiver. Consumes the receiver's byte stream (valid pulse, data, frame error) and parses length-prefixed messages with an optional additive checksum. Stores each message in a local buffer and releases it on a valid/ready stream only after the whole message is accepted as good (store-and-forward). Malformed or corrupted messages are dropped and flagged.

## Interface
- BYTE_SIZE, 8, width of every byte on input and output
- MAX_LEN, 16, maximum payload bytes per message (≥1); buffer depth
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- in_valid  in  1  one-cycle strobe: in_data holds a received byte
- in_data  in  BYTE_SIZE  received byte
- in_err  in  1  receiver frame error (start bit high), sampled every cycle
- out_ready  in  1  downstream accepts out_data this cycle
- out_valid  out  1  out_data holds a payload byte of a good message
- out_data  out  BYTE_SIZE  payload byte, in arrival order
- out_last  out  1  qualifies final payload byte of the message
- msg_done  out  1  one-cycle pulse: a message was fully drained
- msg_bad  out  1  one-cycle pulse: a message was dropped
- overrun  out  1  one-cycle pulse: input byte discarded during drain
- busy  out  1  high in any state other than ST_LEN

## Operation
- Message format: LEN byte (1..MAX_LEN), LEN payload bytes, then checksum byte (when enabled) = (LEN + Σpayload) mod 2^BYTE_SIZE.
- FSM states: ST_LEN, ST_PAYLOAD, ST_CSUM, ST_DRAIN. Reset state ST_LEN.
- ST_LEN: on in_valid: LEN=0 or LEN>MAX_LEN → msg_bad, stay; else latch len, sum←LEN, idx←0, go ST_PAYLOAD.
- ST_PAYLOAD: on in_valid: buf[idx]←in_data, sum←sum+in_data, idx++; on byte idx==len-1 go ST_CSUM (ST_DRAIN if checksum disabled).
- ST_CSUM: on in_valid: in_data==sum → ST_DRAIN; else msg_bad, ST_LEN.
- ST_DRAIN: rd_idx from 0; out_valid high; out_data=buf[rd_idx]; out_last=(rd_idx==len-1). Handshake = out_valid&&out_ready advances rd_idx; handshake with out_last → ST_LEN.
- in_err high in ST_PAYLOAD or ST_CSUM → abort: msg_bad, ST_LEN, takes priority over in_valid that cycle. in_err in ST_LEN or ST_DRAIN ignored.
- in_valid in ST_DRAIN: byte discarded, overrun pulse; drain continues.
- Checksum arithmetic wraps modulo 2^BYTE_SIZE; idx/len counters width $clog2(MAX_LEN+1).

## Timing
- All outputs registered; reset value 0 for out_valid, out_data, out_last, msg_done, msg_bad, overrun, busy.
- out_valid rises the cycle after the accepting byte (checksum or last payload) is strobed.
- One byte per cycle on output while out_ready high; out_data/out_last stable while out_valid&&!out_ready.
- msg_done pulses the cycle after the out_last handshake, same cycle out_valid falls; a LEN byte strobed in that cycle is accepted.
- msg_bad/overrun pulse the cycle after the offending strobe.
- Back-to-back in_valid every cycle supported.
- RST mid-message or mid-drain: buffer contents abandoned, ST_LEN next cycle, no msg_bad.

## Configuration
- UART_MSG_CSUM_EN defined: ST_CSUM present, checksum byte required and checked.
- Undefined: no checksum byte; ST_CSUM and sum register removed; ST_PAYLOAD goes directly to ST_DRAIN after last payload byte; message never rejected for content, only LEN range or in_err.

## Test plan
- Good message 03,11,22,33,69 (CSUM_EN), out_ready=1 → out 11,22,33 on consecutive cycles, out_last on 33, msg_done next cycle.
- Bad checksum 02,AA,BB,00 → msg_bad one pulse, no out_valid; following 01,5A,5B drains 5A.
- LEN=00 and LEN=MAX_LEN+1 → msg_bad each, stays ST_LEN, busy stays 0.
- in_err during payload of 03,01,02 → msg_bad, abort; next message received intact.
- out_ready toggling 1,0,0,1 during drain of 4-byte message → data held while stalled, all 4 bytes in order; in_valid during drain → overrun pulse, byte lost.
- RST asserted mid-drain → out_valid 0 next cycle, next message parsed from LEN.
